// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU/CSR writeback
// path and the load-return path. Loads cannot be stalled and always win.
// ALU results that cannot be written right away wait in a small in-order FIFO
// and are drained whenever no load claims the port. Writes to x0 are dropped.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   alu_valid/alu_ready  ALU result handshake (ready = FIFO not full)
//   alu_rd, alu_data     ALU destination register and result
//   ld_valid             load data returning this cycle (must be taken)
//   ld_rd, ld_data       load destination register and extended data
//   rf_we/waddr/wdata    registered register-file write port
//   rs1, rs2             decode-stage source registers
//   busy1, busy2         a write to rs1/rs2 is still pending in this block
//   stall_cnt            (WB_STALL_CNT_EN only) saturating count of cycles
//                        in which the ALU offered a result but was stalled
//
// Optional feature macro: WB_STALL_CNT_EN
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            busy1,
  output logic            busy2
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [PTRW-1:0] headPtr_q, tailPtr_q;
  logic [CNTW-1:0] count_q;
  logic [4:0]      rdMem_q   [DEPTH];
  logic [XLEN-1:0] dataMem_q [DEPTH];

  logic            rfWe_q, rfWe_d;
  logic [4:0]      rfWaddr_q, rfWaddr_d;
  logic [XLEN-1:0] rfWdata_q, rfWdata_d;

  logic full, empty, ldSel, aluTake, popEn, directEn, pushEn;
  logic [PTRW-1:0] scanIdx;

  // Source selection for the output stage. Loads win, then the FIFO head, and
  // only an empty FIFO lets a fresh ALU result bypass straight to the port so
  // that ALU results stay in acceptance order.
  always_comb begin
    full      = (count_q == CNTW'(DEPTH));
    empty     = (count_q == '0);
    alu_ready = !full;
    ldSel     = ld_valid && (ld_rd != 5'd0);
    aluTake   = alu_valid && !full && (alu_rd != 5'd0);
    popEn     = !ldSel && !empty;
    directEn  = !ldSel && empty && aluTake;
    pushEn    = aluTake && !directEn;

    rfWe_d    = 1'b0;
    rfWaddr_d = rfWaddr_q;
    rfWdata_d = rfWdata_q;
    if (ldSel) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = ld_rd;
      rfWdata_d = ld_data;
    end else if (popEn) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = rdMem_q[headPtr_q];
      rfWdata_d = dataMem_q[headPtr_q];
    end else if (directEn) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = alu_rd;
      rfWdata_d = alu_data;
    end
  end

  // Output stage and FIFO bookkeeping. Pointers wrap naturally because DEPTH
  // is a power of two; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rfWe_q    <= 1'b0;
      rfWaddr_q <= 5'd0;
      rfWdata_q <= '0;
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      rfWe_q    <= rfWe_d;
      rfWaddr_q <= rfWaddr_d;
      rfWdata_q <= rfWdata_d;
      if (pushEn) tailPtr_q <= tailPtr_q + PTRW'(1);
      if (popEn)  headPtr_q <= headPtr_q + PTRW'(1);
      case ({pushEn, popEn})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage needs no reset: the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      rdMem_q[tailPtr_q]   <= alu_rd;
      dataMem_q[tailPtr_q] <= alu_data;
    end
  end

  assign rf_we    = rfWe_q;
  assign rf_waddr = rfWaddr_q;
  assign rf_wdata = rfWdata_q;

  // Hazard flags: a register is busy if the output stage is about to write it
  // or any live FIFO slot targets it. Slots are scanned relative to the head
  // so that stale entries beyond the count are ignored. x0 is never busy.
  always_comb begin
    busy1   = rfWe_q && (rfWaddr_q == rs1);
    busy2   = rfWe_q && (rfWaddr_q == rs2);
    scanIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = headPtr_q + PTRW'(i);
      if (CNTW'(i) < count_q) begin
        if (rdMem_q[scanIdx] == rs1) busy1 = 1'b1;
        if (rdMem_q[scanIdx] == rs2) busy2 = 1'b1;
      end
    end
    if (rs1 == 5'd0) busy1 = 1'b0;
    if (rs2 == 5'd0) busy2 = 1'b0;
  end

`ifdef WB_STALL_CNT_EN
  logic [15:0] stallCnt_q;

  // Counts cycles the ALU was held off by a full FIFO, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_q <= 16'd0;
    end else if (alu_valid && full && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule
